// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - byte-serial memory controller with data/IF port arbitration
// Each request becomes N byte-wide accesses on a single-port synchronous RAM.
module mem_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_require_i,
  input  logic        mem_wr_i,
  input  logic [31:0] mem_addr_i,
  input  logic [2:0]  mem_length_i,
  input  logic [31:0] mem_data_i,
  output logic        mem_busy_o,
  output logic        mem_enable_o,
  output logic [31:0] mem_data_o,
  input  logic        if_require_i,
  input  logic [31:0] if_addr_i,
  output logic        if_busy_o,
  output logic        if_enable_o,
  output logic [31:0] if_data_o,
  input  logic [7:0]  ram_din,
  output logic [7:0]  ram_dout,
  output logic [31:0] ram_a,
  output logic        ram_wr
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t      state;
  state_t      state_next;
  logic        owner_if;
  logic        is_write;
  logic [31:0] base;
  logic [31:0] wdata;
  logic [31:0] rbuf;
  logic [2:0]  len;
  logic [2:0]  idx;
  logic        len_ok;
  logic        grant_mem;
  logic        grant_if;
  logic [31:0] cur_addr;
  logic [1:0]  cap_sel;

  assign len_ok    = (mem_length_i == 3'b001) || (mem_length_i == 3'b010) ||
                     (mem_length_i == 3'b100);
  assign grant_mem = (state == IDLE) && mem_require_i && len_ok;
  assign grant_if  = (state == IDLE) && !grant_mem && if_require_i;
  assign cur_addr  = base + {29'd0, idx};
  // RAM data lags its address by one cycle, so index i carries byte i-1
  assign cap_sel   = idx[1:0] - 2'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_if <= 1'b0;
      is_write <= 1'b0;
      base     <= 32'd0;
      len      <= 3'd0;
      idx      <= 3'd0;
      wdata    <= 32'd0;
      rbuf     <= 32'd0;
    end else if (grant_mem) begin
      owner_if <= 1'b0;
      is_write <= mem_wr_i;
      base     <= mem_addr_i;
      len      <= mem_length_i;
      idx      <= 3'd0;
      wdata    <= mem_data_i;
      rbuf     <= 32'd0;
    end else if (grant_if) begin
      owner_if <= 1'b1;
      is_write <= 1'b0;
      base     <= if_addr_i;
      len      <= 3'd4;
      idx      <= 3'd0;
      wdata    <= 32'd0;
      rbuf     <= 32'd0;
    end else if (state == READ) begin
      if (idx != 3'd0) begin
        rbuf[{cap_sel, 3'b000} +: 8] <= ram_din;
      end
      idx <= idx + 3'd1;
    end else if (state == WRITE) begin
      idx <= idx + 3'd1;
    end
  end

  always_comb begin
    state_next   = state;
    mem_busy_o   = 1'b1;
    if_busy_o    = 1'b1;
    mem_enable_o = 1'b0;
    mem_data_o   = 32'd0;
    if_enable_o  = 1'b0;
    if_data_o    = 32'd0;
    ram_a        = 32'd0;
    ram_dout     = 8'd0;
    ram_wr       = 1'b0;
    case (state)
      IDLE: begin
        mem_busy_o = 1'b0;
        if_busy_o  = 1'b0;
        if (grant_mem) begin
          state_next = mem_wr_i ? WRITE : READ;
        end else if (grant_if) begin
          state_next = READ;
        end
      end
      READ: begin
        if (idx < len) begin
          ram_a = cur_addr;
        end
        if (idx == len) begin
          state_next = DONE;
        end
      end
      WRITE: begin
        ram_a    = cur_addr;
        ram_wr   = 1'b1;
        ram_dout = wdata[{idx[1:0], 3'b000} +: 8];
        if (idx == len - 3'd1) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
        if (owner_if) begin
          if_enable_o = 1'b1;
          if_data_o   = rbuf;
        end else begin
          mem_enable_o = 1'b1;
          mem_data_o   = is_write ? 32'd0 : rbuf;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - scoreboard bench for mem_ctrl with byte-array reference model
// Stimulus pushes expected completions/writes; a negedge monitor pops and compares.
module tb_mem_ctrl;

  logic        clk;
  logic        rst;
  logic        mem_require_i;
  logic        mem_wr_i;
  logic [31:0] mem_addr_i;
  logic [2:0]  mem_length_i;
  logic [31:0] mem_data_i;
  logic        mem_busy_o;
  logic        mem_enable_o;
  logic [31:0] mem_data_o;
  logic        if_require_i;
  logic [31:0] if_addr_i;
  logic        if_busy_o;
  logic        if_enable_o;
  logic [31:0] if_data_o;
  logic [7:0]  ram_din;
  logic [7:0]  ram_dout;
  logic [31:0] ram_a;
  logic        ram_wr;

  mem_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .mem_require_i(mem_require_i),
    .mem_wr_i     (mem_wr_i),
    .mem_addr_i   (mem_addr_i),
    .mem_length_i (mem_length_i),
    .mem_data_i   (mem_data_i),
    .mem_busy_o   (mem_busy_o),
    .mem_enable_o (mem_enable_o),
    .mem_data_o   (mem_data_o),
    .if_require_i (if_require_i),
    .if_addr_i    (if_addr_i),
    .if_busy_o    (if_busy_o),
    .if_enable_o  (if_enable_o),
    .if_data_o    (if_data_o),
    .ram_din      (ram_din),
    .ram_dout     (ram_dout),
    .ram_a        (ram_a),
    .ram_wr       (ram_wr)
  );

  typedef struct {
    bit          is_if;
    logic [31:0] data;
    int unsigned cyc;
  } comp_t;

  typedef struct {
    int unsigned cyc;
    logic [31:0] a;
    logic [7:0]  d;
  } wr_t;

  comp_t       comp_q[$];
  wr_t         wr_q[$];
  logic [7:0]  ram [logic [31:0]];
  logic [7:0]  ref_mem [logic [31:0]];
  int unsigned cyc;
  int unsigned busy_start;
  int unsigned busy_end;
  int          checks;
  int          errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] init_byte(input logic [31:0] a);
    logic [31:0] h;
    h = a * 32'h9E3779B1;
    return h[31:24];
  endfunction

  function automatic logic [7:0] rd_ram(input logic [31:0] a);
    if (ram.exists(a)) return ram[a];
    return init_byte(a);
  endfunction

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_byte(a);
  endfunction

  // Bench-side synchronous single-port RAM
  always @(posedge clk) begin
    if (ram_wr) ram[ram_a] = ram_dout;
    ram_din <= rd_ram(ram_a);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    logic  exp_busy;
    comp_t e;
    wr_t   w;
    exp_busy = (cyc >= busy_start) && (cyc <= busy_end);
    check("busy", {30'd0, mem_busy_o, if_busy_o}, exp_busy ? 32'd3 : 32'd0);
    check("mem_data_quiet", mem_enable_o ? 32'd0 : mem_data_o, 32'd0);
    check("if_data_quiet", if_enable_o ? 32'd0 : if_data_o, 32'd0);
    if (mem_enable_o || if_enable_o) begin
      if (comp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_enable: got mem=%0b if=%0b expected none (cycle %0d)",
                 mem_enable_o, if_enable_o, cyc);
      end else begin
        e = comp_q.pop_front();
        check("enable_port", {30'd0, mem_enable_o, if_enable_o}, e.is_if ? 32'd1 : 32'd2);
        check("enable_cycle", cyc, e.cyc);
        check("read_data", e.is_if ? if_data_o : mem_data_o, e.data);
      end
    end
    if (ram_wr) begin
      if (wr_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %h data %h expected none (cycle %0d)",
                 ram_a, ram_dout, cyc);
      end else begin
        w = wr_q.pop_front();
        check("write_cycle", cyc, w.cyc);
        check("write_addr", ram_a, w.a);
        check("write_data", {24'd0, ram_dout}, {24'd0, w.d});
      end
    end else begin
      check("ram_dout_quiet", {24'd0, ram_dout}, 32'd0);
    end
  end

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (cyc <= busy_end && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 100) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: got busy after %0d cycles expected idle", guard);
    end
  endtask

  // Called at posedge+1 of an idle cycle; that cycle is the request cycle 0.
  task automatic issue(input bit use_mem, input bit use_if, input bit wr,
                       input logic [31:0] addr, input logic [2:0] len,
                       input logic [31:0] data, input logic [31:0] iaddr);
    int unsigned c0;
    logic [31:0] v;
    bit          len_ok;
    c0 = cyc;
    mem_require_i = use_mem;
    mem_wr_i      = wr;
    mem_addr_i    = addr;
    mem_length_i  = len;
    mem_data_i    = data;
    if_require_i  = use_if;
    if_addr_i     = iaddr;
    len_ok = (len == 3'd1) || (len == 3'd2) || (len == 3'd4);
    if (use_mem && len_ok) begin
      busy_start = c0 + 1;
      if (wr) begin
        for (int k = 0; k < int'(len); k++) begin
          wr_q.push_back('{cyc: c0 + 1 + k, a: addr + 32'(k), d: data[8*k +: 8]});
          ref_mem[addr + 32'(k)] = data[8*k +: 8];
        end
        busy_end = c0 + len + 1;
        comp_q.push_back('{is_if: 1'b0, data: 32'd0, cyc: busy_end});
      end else begin
        v = 32'd0;
        for (int k = 0; k < int'(len); k++) v[8*k +: 8] = ref_rd(addr + 32'(k));
        busy_end = c0 + len + 2;
        comp_q.push_back('{is_if: 1'b0, data: v, cyc: busy_end});
      end
    end else if (use_if) begin
      v = 32'd0;
      for (int k = 0; k < 4; k++) v[8*k +: 8] = ref_rd(iaddr + 32'(k));
      busy_start = c0 + 1;
      busy_end   = c0 + 6;
      comp_q.push_back('{is_if: 1'b1, data: v, cyc: busy_end});
    end
    @(posedge clk); #1;
    mem_require_i = 1'b0;
    if_require_i  = 1'b0;
    mem_wr_i      = 1'($urandom);
    mem_addr_i    = $urandom;
    mem_length_i  = 3'($urandom);
    mem_data_i    = $urandom;
    if_addr_i     = $urandom;
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin
    int unsigned c0;
    int          kind;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] ia;
    logic [2:0]  l;
    logic [2:0]  bad;
    checks = 0;
    errors = 0;
    busy_start = 1;
    busy_end   = 0;
    rst = 1'b0;
    mem_require_i = 1'b0;
    mem_wr_i      = 1'b0;
    mem_addr_i    = 32'd0;
    mem_length_i  = 3'd0;
    mem_data_i    = 32'd0;
    if_require_i  = 1'b0;
    if_addr_i     = 32'd0;
    for (int k = 0; k < 4; k++) begin
      ram[32'h100 + 32'(k)]     = 8'h11 * 8'(k + 1);
      ref_mem[32'h100 + 32'(k)] = 8'h11 * 8'(k + 1);
    end
    #1;
    check("reset_busy", {30'd0, mem_busy_o, if_busy_o}, 32'd0);
    check("reset_enable", {30'd0, mem_enable_o, if_enable_o}, 32'd0);
    check("reset_mem_data", mem_data_o, 32'd0);
    check("reset_if_data", if_data_o, 32'd0);
    check("reset_ram_a", ram_a, 32'd0);
    check("reset_ram_wr", {31'd0, ram_wr}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;

    issue(1, 0, 0, 32'h100, 3'd4, 32'd0, 32'd0);
    issue(1, 0, 0, 32'h103, 3'd1, 32'd0, 32'd0);
    issue(1, 0, 0, 32'h102, 3'd2, 32'd0, 32'd0);
    issue(1, 0, 1, 32'h200, 3'd2, 32'hDEADBEEF, 32'd0);
    issue(1, 0, 0, 32'h200, 3'd4, 32'd0, 32'd0);
    issue(1, 1, 0, 32'h100, 3'd4, 32'd0, 32'h100);
    issue(0, 1, 0, 32'd0, 3'd0, 32'd0, 32'h100);
    issue(1, 1, 1, 32'h204, 3'd4, 32'h01234567, 32'h100);
    issue(1, 0, 0, 32'hFFFFFFFE, 3'd4, 32'd0, 32'd0);
    issue(1, 1, 0, 32'h100, 3'd3, 32'd0, 32'h101);

    // Word write aborted by reset in its second cycle: only byte 0 lands
    c0 = cyc;
    mem_require_i = 1'b1;
    mem_wr_i      = 1'b1;
    mem_addr_i    = 32'h400;
    mem_length_i  = 3'd4;
    mem_data_i    = 32'hA1B2C3D4;
    busy_start = c0 + 1;
    busy_end   = c0 + 1;
    wr_q.push_back('{cyc: c0 + 1, a: 32'h400, d: 8'hD4});
    ref_mem[32'h400] = 8'hD4;
    @(posedge clk); #1;
    mem_require_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("abort_ram_wr", {31'd0, ram_wr}, 32'd0);
    check("abort_busy", {30'd0, mem_busy_o, if_busy_o}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    issue(1, 0, 0, 32'h400, 3'd4, 32'd0, 32'd0);

    for (int t = 0; t < 40; t++) begin
      kind = $urandom_range(0, 9);
      a  = ($urandom_range(0, 7) == 0) ? $urandom : 32'h300 + $urandom_range(0, 63);
      ia = 32'h300 + $urandom_range(0, 63);
      d  = $urandom;
      case ($urandom_range(0, 2))
        0:       l = 3'd1;
        1:       l = 3'd2;
        default: l = 3'd4;
      endcase
      bad = ($urandom_range(0, 1) == 1) ? 3'd3 : 3'($urandom_range(5, 7));
      case (kind)
        0, 1, 2, 3: issue(1, 0, 0, a, l, d, ia);
        4, 5, 6:    issue(1, 0, 1, a, l, d, ia);
        7:          issue(0, 1, 0, a, l, d, ia);
        8:          issue(1, 1, 1'($urandom), a, l, d, ia);
        default:    issue(1, 1'($urandom), 0, a, bad, d, ia);
      endcase
    end

    repeat (3) @(posedge clk);
    #1;
    check("comp_q_drained", comp_q.size(), 32'd0);
    check("wr_q_drained", wr_q.size(), 32'd0);
    foreach (ref_mem[k]) check("ram_content", {24'd0, rd_ram(k)}, {24'd0, ref_mem[k]});
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Memory controller at the far end of the pipeline's memory-request interface. Accepts word/half/byte read and write requests from the MEM stage (data port) and whole-word reads from instruction fetch (IF port). Serializes each request into byte-wide accesses on a single-port synchronous RAM, then returns read data with a one-cycle completion pulse. Data port has fixed priority over the IF port.

## Interface
- No parameters; all widths fixed.
- clk  input  1  system clock, rising edge.
- rst  input  1  reset; asynchronous, active-low.
- mem_require_i  input  1  data-port request strobe.
- mem_wr_i  input  1  1 = write, 0 = read.
- mem_addr_i  input  32  data-port byte address.
- mem_length_i  input  3  bytes to transfer: 3'b001, 3'b010 or 3'b100.
- mem_data_i  input  32  write data, little-endian, low `length` bytes used.
- mem_busy_o  output  1  controller not accepting data-port requests.
- mem_enable_o  output  1  one-cycle data-port completion pulse.
- mem_data_o  output  32  data-port read result, unused high bytes zero.
- if_require_i  input  1  IF-port request strobe (always a 4-byte read).
- if_addr_i  input  32  IF-port byte address.
- if_busy_o  output  1  controller not accepting IF-port requests.
- if_enable_o  output  1  one-cycle IF-port completion pulse.
- if_data_o  output  32  fetched instruction word.
- ram_din  input  8  RAM read byte; valid the cycle after its address.
- ram_dout  output  8  RAM write byte.
- ram_a  output  32  RAM byte address.
- ram_wr  output  1  RAM write enable.

## Operation
- States: IDLE, READ, WRITE, DONE. Registers: owner (DATA/IF), base addr, length N, byte index i (0..N), write data, read-assembly buffer.
- IDLE: mem_busy_o = if_busy_o = 0. On a clock edge with mem_require_i=1 and valid length: latch data request, owner=DATA, i=0, go READ or WRITE per mem_wr_i. Else if if_require_i=1: latch IF request, owner=IF, N=4, go READ. Invalid mem_length_i (anything but 1/2/4) is ignored; IF may be granted in its place.
- Any state other than IDLE: both busy outputs = 1. A requester that lost arbitration simply re-requests after busy drops; the controller keeps no pending record.
- READ: cycles with i<N drive ram_a = base+i, ram_wr=0. ram_din captured into buffer byte i-1 at each edge for i≥1. After capturing byte N-1, go DONE.
- WRITE: each cycle drive ram_a = base+i, ram_wr=1, ram_dout = write-data byte i; after byte N-1, go DONE.
- DONE: pulse owner's enable for exactly one cycle, present result on owner's data output (zero for writes). Next state IDLE unconditionally.
- Address arithmetic: base+i modulo 2^32 (0xFFFFFFFF+1 wraps to 0).
- Read assembly little-endian: byte at base+k → bits [8k+7:8k]; bytes ≥N zero.
- Outputs when not driving: ram_a=0, ram_dout=0, ram_wr=0; mem_data_o/if_data_o=0 outside their DONE cycle.

## Timing
- Reset (rst=0, asynchronous): state IDLE, all outputs 0, buffers cleared. Reset mid-transaction aborts it: no enable pulse, ram_wr drops immediately, partial write is not undone.
- Request sampled at edge E0 (cycle 0). Read of N bytes: ram_a=base+k in cycle k+1; enable in cycle N+2 (word read: cycle 6). Write of N bytes: ram_wr in cycles 1..N; enable in cycle N+1.
- Earliest next acceptance: edge ending the cycle after DONE (IDLE cycle). Back-to-back word reads: one every 7 cycles.
- Simultaneous data and IF request in IDLE: data wins; if_busy_o goes 1 next cycle.
- Requester fields need only be valid at the accepting edge; later changes ignored.

## Test plan
- Word read: RAM[0x100..0x103]=11,22,33,44; mem_require_i, addr 0x100, len 4, cycle 0 -> ram_a 0x100..0x103 in cycles 1-4, mem_enable_o=1 only in cycle 6, mem_data_o=0x44332211.
- Signed/short reads: len 1 at 0x103 -> mem_data_o=0x00000044 at cycle 3; len 2 at 0x102 -> 0x00004433 at cycle 4.
- Half-word write: addr 0x200, data 0xDEADBEEF, len 2 -> ram_wr=1 cycles 1-2 with (0x200,EF),(0x201,BE); mem_enable_o cycle 3; RAM[0x202] untouched.
- Arbitration: mem and IF both request in same IDLE cycle -> data served first, if_busy_o=1 throughout; IF re-request after completion -> if_enable_o with correct word, mem_enable_o never pulses for it.
- Wrap: word read at 0xFFFFFFFE -> ram_a sequence FFFFFFFE, FFFFFFFF, 00000000, 00000001.
- Reset mid-write: rst low during cycle 2 of word write -> ram_wr=0 and busy=0 immediately, no enable pulse; new request after release completes normally.
